// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - floating-point matrix multiply O = A*B (+bias, relu) on P shared MAC lanes
// Contains the mul_float/add_float units (one-cycle start/done handshake) and the matmul_mac top.

module mul_float #(
  parameter int S = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S-1:0] x,
  input  logic [S-1:0] y,
  output logic [S-1:0] res,
  output logic         done,
  output logic         nan,
  output logic         ovf
);
  localparam int EW = (S == 64) ? 11 : ((S == 16) ? 5 : 8);
  localparam int MW = S - 1 - EW;
  localparam int PW = 2 * (MW + 1);
  localparam int EMAX = (1 << EW) - 1;
  localparam int BIAS = (1 << (EW - 1)) - 1;

  logic [S-1:0]  r;
  logic          f_nan, f_ovf, sgn, xi, yi, xz, yz, hi, g, st, rnd, cy;
  logic [PW-1:0] prod;
  logic [MW-1:0] mant, mr;
  int            ex;

  // Subnormal inputs flush to zero; rounding is nearest-even.
  always_comb begin
    r = '0;
    f_nan = 1'b0;
    f_ovf = 1'b0;
    sgn = x[S-1] ^ y[S-1];
    xi = &x[S-2:MW];
    yi = &y[S-2:MW];
    xz = ~|x[S-2:MW];
    yz = ~|y[S-2:MW];
    prod = {1'b1, x[MW-1:0]} * {1'b1, y[MW-1:0]};
    hi = prod[PW-1];
    mant = hi ? prod[PW-2 -: MW] : prod[PW-3 -: MW];
    g = hi ? prod[PW-2-MW] : prod[PW-3-MW];
    st = hi ? |prod[PW-3-MW:0] : |prod[PW-4-MW:0];
    rnd = g & (st | mant[0]);
    {cy, mr} = {1'b0, mant} + {{MW{1'b0}}, rnd};
    ex = int'(x[S-2:MW]) + int'(y[S-2:MW]) - BIAS + int'(hi) + int'(cy);
    if ((xi && |x[MW-1:0]) || (yi && |y[MW-1:0]) || (xi && yz) || (yi && xz)) begin
      r = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      f_nan = 1'b1;
    end else if (xi || yi) r = {sgn, {EW{1'b1}}, {MW{1'b0}}};
    else if (xz || yz) r = {sgn, {(S-1){1'b0}}};
    else if (ex >= EMAX) begin
      r = {sgn, {EW{1'b1}}, {MW{1'b0}}};
      f_ovf = 1'b1;
    end else if (ex <= 0) r = {sgn, {(S-1){1'b0}}};
    else r = {sgn, ex[EW-1:0], mr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      done <= 1'b0;
      nan <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        res <= r;
        nan <= f_nan;
        ovf <= f_ovf;
      end
    end
  end
endmodule

module add_float #(
  parameter int S = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S-1:0] x,
  input  logic [S-1:0] y,
  output logic [S-1:0] res,
  output logic         done,
  output logic         nan,
  output logic         ovf
);
  localparam int EW = (S == 64) ? 11 : ((S == 16) ? 5 : 8);
  localparam int MW = S - 1 - EW;
  localparam int X = MW + 4;
  localparam int EMAX = (1 << EW) - 1;

  logic [S-1:0]  r, bg, sm;
  logic          f_nan, f_ovf, xi, yi, xz, yz, rnd, cy;
  logic [X-1:0]  mb_e, ms_e, al, sn;
  logic [X:0]    sum;
  logic [MW-1:0] mr;
  int            d, msb, ex;

  // Larger magnitude is kept as the reference; the smaller is aligned with a sticky bit.
  always_comb begin
    r = '0;
    f_nan = 1'b0;
    f_ovf = 1'b0;
    xi = &x[S-2:MW];
    yi = &y[S-2:MW];
    xz = ~|x[S-2:MW];
    yz = ~|y[S-2:MW];
    bg = (x[S-2:0] < y[S-2:0]) ? y : x;
    sm = (x[S-2:0] < y[S-2:0]) ? x : y;
    d = int'(bg[S-2:MW]) - int'(sm[S-2:MW]);
    mb_e = {1'b1, bg[MW-1:0], 3'b000};
    ms_e = {1'b1, sm[MW-1:0], 3'b000};
    if (d >= X) al = {{(X-1){1'b0}}, 1'b1};
    else al = (ms_e >> d) | {{(X-1){1'b0}}, |(ms_e & ~({X{1'b1}} << d))};
    sum = (bg[S-1] == sm[S-1]) ? {1'b0, mb_e} + {1'b0, al} : {1'b0, mb_e} - {1'b0, al};
    msb = 0;
    for (int n = 0; n <= X; n++) if (sum[n]) msb = n;
    sn = X'(sum << (X - msb));
    rnd = sn[3] & (|sn[2:0] | sn[4]);
    {cy, mr} = {1'b0, sn[X-1 -: MW]} + {{MW{1'b0}}, rnd};
    ex = int'(bg[S-2:MW]) + msb - (X - 1) + int'(cy);
    if ((xi && |x[MW-1:0]) || (yi && |y[MW-1:0]) || (xi && yi && (x[S-1] != y[S-1]))) begin
      r = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      f_nan = 1'b1;
    end else if (xi) r = x;
    else if (yi) r = y;
    else if (xz && yz) r = {x[S-1] & y[S-1], {(S-1){1'b0}}};
    else if (xz) r = y;
    else if (yz) r = x;
    else if (sum == '0) r = '0;
    else if (ex >= EMAX) begin
      r = {bg[S-1], {EW{1'b1}}, {MW{1'b0}}};
      f_ovf = 1'b1;
    end else if (ex <= 0) r = {bg[S-1], {(S-1){1'b0}}};
    else r = {bg[S-1], ex[EW-1:0], mr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      done <= 1'b0;
      nan <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        res <= r;
        nan <= f_nan;
        ovf <= f_ovf;
      end
    end
  end
endmodule

module matmul_mac #(
  parameter int S = 32,
  parameter int H = 2,
  parameter int C = 2,
  parameter int W = 2,
  parameter int P = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bias_en,
  input  logic             relu_en,
  input  logic [S*H*C-1:0] a,
  input  logic [S*C*W-1:0] b,
  input  logic [S*W-1:0]   bias,
  output logic [S*H*W-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             err_nan,
  output logic             err_ovf
);
  localparam int EW = (S == 64) ? 11 : ((S == 16) ? 5 : 8);
  localparam int MW = S - 1 - EW;
  localparam int G = H * W / P;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int KW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [2:0] {IDLE, MUL, ADD, BIAS, WRITE, DONE} state_t;
  state_t state, state_n;

  logic [S*H*C-1:0]    a_q;
  logic [S*C*W-1:0]    b_q;
  logic [S*W-1:0]      bias_q;
  logic                bias_en_q, relu_q, issue, issue_n, mul_go, add_go, all_mdone, all_adone;
  logic [GW-1:0]       grp;
  logic [KW-1:0]       k;
  logic [P-1:0][S-1:0] mx, my, bj, ax, ay, mres, ares, acc, prd, wr;
  logic [P-1:0]        mdone, adone, mnan, movf, anan, aovf;

  assign all_mdone = &mdone;
  assign all_adone = &adone;
  assign mul_go = issue && (state == MUL);
  assign add_go = issue && ((state == ADD) || (state == BIAS));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // The first product of an element is taken as-is (k=0), so MUL re-enters itself once before ADD.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = MUL;
      MUL:   if (all_mdone) begin
               if (C == 1) state_n = bias_en_q ? BIAS : WRITE;
               else state_n = (k == '0) ? MUL : ADD;
             end
      ADD:   if (all_adone) begin
               if (int'(k) < C - 1) state_n = MUL;
               else state_n = bias_en_q ? BIAS : WRITE;
             end
      BIAS:  if (all_adone) state_n = WRITE;
      WRITE: state_n = (int'(grp) == G - 1) ? DONE : MUL;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    issue_n = ((state_n == MUL) || (state_n == ADD) || (state_n == BIAS)) &&
              ((state_n != state) || ((state == MUL) && all_mdone));
  end

  always_comb begin
    mx = '0;
    my = '0;
    bj = '0;
    for (int l = 0; l < P; l++) begin
      for (int n = 0; n < H * C; n++)
        if (n == ((int'(grp) * P + l) / W) * C + int'(k)) mx[l] = a_q[(H*C-1-n)*S +: S];
      for (int n = 0; n < C * W; n++)
        if (n == int'(k) * W + (int'(grp) * P + l) % W) my[l] = b_q[(C*W-1-n)*S +: S];
      for (int n = 0; n < W; n++)
        if (n == (int'(grp) * P + l) % W) bj[l] = bias_q[(W-1-n)*S +: S];
    end
  end

  always_comb begin
    ax = acc;
    ay = (state == BIAS) ? bj : prd;
    for (int l = 0; l < P; l++)
      wr[l] = (relu_q && acc[l][S-1] && !(&acc[l][S-2:MW] && |acc[l][MW-1:0])) ? '0 : acc[l];
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    mul_float #(.S(S)) u_mul (
      .clk(clk), .rst_n(rst_n), .start(mul_go), .x(mx[l]), .y(my[l]),
      .res(mres[l]), .done(mdone[l]), .nan(mnan[l]), .ovf(movf[l])
    );
    add_float #(.S(S)) u_add (
      .clk(clk), .rst_n(rst_n), .start(add_go), .x(ax[l]), .y(ay[l]),
      .res(ares[l]), .done(adone[l]), .nan(anan[l]), .ovf(aovf[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      bias_q <= '0;
      bias_en_q <= 1'b0;
      relu_q <= 1'b0;
      issue <= 1'b0;
      grp <= '0;
      k <= '0;
      acc <= '0;
      prd <= '0;
      o <= '0;
      err_nan <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      issue <= issue_n;
      err_nan <= err_nan | (|(mdone & mnan)) | (|(adone & anan));
      err_ovf <= err_ovf | (|(mdone & movf)) | (|(adone & aovf));
      case (state)
        IDLE: if (start) begin
          a_q <= a;
          b_q <= b;
          bias_q <= bias;
          bias_en_q <= bias_en;
          relu_q <= relu_en;
          grp <= '0;
          k <= '0;
          err_nan <= 1'b0;
          err_ovf <= 1'b0;
        end
        MUL: if (all_mdone) begin
          prd <= mres;
          if (k == '0) begin
            // Accumulation starts from +0.0, so a -0.0 first product becomes +0.0.
            for (int l = 0; l < P; l++) acc[l] <= (mres[l][S-2:0] == '0) ? '0 : mres[l];
            if (C > 1) k <= k + 1'b1;
          end
        end
        ADD: if (all_adone) begin
          acc <= ares;
          if (int'(k) < C - 1) k <= k + 1'b1;
        end
        BIAS: if (all_adone) acc <= ares;
        WRITE: begin
          for (int n = 0; n < H * W; n++)
            for (int l = 0; l < P; l++)
              if (n == int'(grp) * P + l) o[(H*W-1-n)*S +: S] <= wr[l];
          grp <= (int'(grp) == G - 1) ? '0 : grp + 1'b1;
          k <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
